// File: rtl/lbus_pkg.sv
// Shared state codes and constants for the local CSR bus initiator.
package lbus_pkg;

   localparam int unsigned LBUS_ADDR_W   = 32;
   localparam logic [31:0] LBUS_ERR_DATA = 32'hDEAD_BEEF;

   typedef logic [1:0] lbus_state_t;

   localparam lbus_state_t ST_IDLE  = 2'd0;
   localparam lbus_state_t ST_WRITE = 2'd1;
   localparam lbus_state_t ST_READ  = 2'd2;

   // Mask keeping the low 'bits' address bits; saturates at the full bus width.
   function automatic logic [LBUS_ADDR_W-1:0] lbus_addr_mask(input int unsigned bits);
      logic [LBUS_ADDR_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < LBUS_ADDR_W; i++) begin
         if (i < bits) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/lbus_timeout_ctr.sv
// Cycle counter that flags expiry once it has counted TIMEOUT-1 cycles since clear.
module lbus_timeout_ctr #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int unsigned CW = $clog2(TIMEOUT) + 1;

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_expired = (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/lbus_master_bridge.sv
// FemtoRV32 native memory bus to local CSR bus initiator with stall and timeout handling.
module lbus_master_bridge
   import lbus_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 28,
   parameter int unsigned TIMEOUT   = 16,
   parameter logic [31:0] ERR_DATA  = LBUS_ERR_DATA
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   sel,
   input  logic [LBUS_ADDR_W-1:0] mem_addr,
   input  logic [31:0]            mem_wdata,
   input  logic [3:0]             mem_wmask,
   input  logic                   mem_rstrb,
   output logic [31:0]            mem_rdata,
   output logic                   mem_rbusy,
   output logic                   mem_wbusy,
   output logic [LBUS_ADDR_W-1:0] waddr,
   output logic [31:0]            wdata,
   output logic [3:0]             wstrb,
   output logic                   wen,
   input  logic                   wready,
   output logic [LBUS_ADDR_W-1:0] raddr,
   output logic                   ren,
   input  logic [31:0]            rdata,
   input  logic                   rvalid,
   output logic                   err
);

   localparam logic [LBUS_ADDR_W-1:0] ADDR_MASK = lbus_addr_mask(ADDR_BITS);

   lbus_state_t            r_state;
   logic [31:0]            r_mem_rdata;
   logic [LBUS_ADDR_W-1:0] r_waddr;
   logic [31:0]            r_wdata;
   logic [3:0]             r_wstrb;
   logic                   r_wen;
   logic [LBUS_ADDR_W-1:0] r_raddr;
   logic                   r_ren;
   logic                   r_err;

   logic                   w_idle;
   logic                   w_wr_req;
   logic                   w_rd_req;
   logic                   w_expired;
   logic [LBUS_ADDR_W-1:0] w_addr;

   assign w_idle   = (r_state == ST_IDLE);
   assign w_wr_req = sel & (|mem_wmask);
   assign w_rd_req = sel & mem_rstrb;
   assign w_addr   = mem_addr & ADDR_MASK;

   // Busy is combinational so the CPU already stalls in the strobe cycle.
   assign mem_wbusy = (r_state == ST_WRITE) | (w_idle & w_wr_req);
   assign mem_rbusy = (r_state == ST_READ)  | (w_idle & w_rd_req);

   lbus_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_ctr (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_clr     (w_idle),
      .i_en      (!w_idle),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_mem_rdata <= '0;
         r_waddr     <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_wen       <= 1'b0;
         r_raddr     <= '0;
         r_ren       <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_wr_req) begin
                  r_waddr <= w_addr;
                  r_wdata <= mem_wdata;
                  r_wstrb <= mem_wmask;
                  r_wen   <= 1'b1;
                  r_state <= ST_WRITE;
               end else if (w_rd_req) begin
                  r_raddr <= w_addr;
                  r_ren   <= 1'b1;
                  r_state <= ST_READ;
               end
            end
            ST_WRITE: begin
               // An ack on the expiry edge takes precedence over the timeout.
               if (wready) begin
                  r_wen   <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (w_expired) begin
                  r_wen   <= 1'b0;
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            ST_READ: begin
               if (rvalid) begin
                  r_mem_rdata <= rdata;
                  r_ren       <= 1'b0;
                  r_state     <= ST_IDLE;
               end else if (w_expired) begin
                  r_mem_rdata <= ERR_DATA;
                  r_ren       <= 1'b0;
                  r_err       <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_wen   <= 1'b0;
               r_ren   <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_rdata = r_mem_rdata;
   assign waddr     = r_waddr;
   assign wdata     = r_wdata;
   assign wstrb     = r_wstrb;
   assign wen       = r_wen;
   assign raddr     = r_raddr;
   assign ren       = r_ren;
   assign err       = r_err;

endmodule

// File: tb/tb_lbus_master_bridge.sv
// Directed and randomized checks of lbus_master_bridge against a transaction-level model.
module tb_lbus_master_bridge;

   localparam int unsigned TO    = 16;
   localparam logic [31:0] ERRD  = 32'hDEAD_BEEF;
   localparam logic [31:0] AMASK = 32'h0FFF_FFFF;
   localparam int          NEVER = 1000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        sel = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wmask = '0;
   logic        mem_rstrb = 1'b0;
   logic [31:0] mem_rdata;
   logic        mem_rbusy;
   logic        mem_wbusy;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wen;
   logic        wready = 1'b0;
   logic [31:0] raddr;
   logic        ren;
   logic [31:0] rdata = '0;
   logic        rvalid = 1'b0;
   logic        err;

   int          n_checks = 0;
   int          n_fail = 0;
   logic        exp_err = 1'b0;
   logic [31:0] exp_rdata = '0;

   always #5 clk = ~clk;

   lbus_master_bridge #(
      .ADDR_BITS (28),
      .TIMEOUT   (TO),
      .ERR_DATA  (ERRD)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .sel       (sel),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wmask (mem_wmask),
      .mem_rstrb (mem_rstrb),
      .mem_rdata (mem_rdata),
      .mem_rbusy (mem_rbusy),
      .mem_wbusy (mem_wbusy),
      .waddr     (waddr),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .wen       (wen),
      .wready    (wready),
      .raddr     (raddr),
      .ren       (ren),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .err       (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Responder acks 'delay' cycles after the request first becomes visible.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                           input int delay, input logic also_rd);
      int busy_cycles;
      busy_cycles = (delay < int'(TO)) ? delay + 1 : int'(TO);
      @(negedge clk);
      sel = 1'b1; mem_addr = a; mem_wdata = d; mem_wmask = m; mem_rstrb = also_rd;
      #1;
      check("wbusy_strobe", mem_wbusy, 1);
      check("wen_strobe", wen, 0);
      @(posedge clk); #1;
      sel = 1'b0; mem_wmask = '0; mem_rstrb = 1'b0;
      mem_addr = $urandom; mem_wdata = $urandom;
      for (int k = 0; k < busy_cycles; k++) begin
         @(negedge clk);
         check("wen_hold", wen, 1);
         check("waddr", waddr, a & AMASK);
         check("wdata", wdata, d);
         check("wstrb", wstrb, m);
         check("wbusy_hold", mem_wbusy, 1);
         check("ren_in_write", ren, 0);
         rvalid = 1'($urandom);
         if (k == delay) wready = 1'b1;
         @(posedge clk); #1;
         wready = 1'b0; rvalid = 1'b0;
      end
      if (delay >= int'(TO)) exp_err = 1'b1;
      @(negedge clk);
      check("wen_done", wen, 0);
      check("wbusy_done", mem_wbusy, 0);
      check("ren_after_write", ren, 0);
      check("err_after_write", err, exp_err);
   endtask

   task automatic do_read(input logic [31:0] a, input logic [31:0] d, input int delay);
      int busy_cycles;
      busy_cycles = (delay < int'(TO)) ? delay + 1 : int'(TO);
      @(negedge clk);
      sel = 1'b1; mem_addr = a; mem_rstrb = 1'b1;
      #1;
      check("rbusy_strobe", mem_rbusy, 1);
      @(posedge clk); #1;
      sel = 1'b0; mem_rstrb = 1'b0; mem_addr = $urandom;
      for (int k = 0; k < busy_cycles; k++) begin
         @(negedge clk);
         check("ren_hold", ren, 1);
         check("raddr", raddr, a & AMASK);
         check("rbusy_hold", mem_rbusy, 1);
         check("rdata_kept", mem_rdata, exp_rdata);
         wready = 1'($urandom);
         rdata = (k == delay) ? d : 32'($urandom);
         if (k == delay) rvalid = 1'b1;
         @(posedge clk); #1;
         rvalid = 1'b0; wready = 1'b0;
      end
      if (delay >= int'(TO)) begin
         exp_err   = 1'b1;
         exp_rdata = ERRD;
      end else begin
         exp_rdata = d;
      end
      @(negedge clk);
      check("ren_done", ren, 0);
      check("rbusy_done", mem_rbusy, 0);
      check("mem_rdata", mem_rdata, exp_rdata);
      check("err_after_read", err, exp_err);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_mem_rdata", mem_rdata, 0);
      check("rst_rbusy", mem_rbusy, 0);
      check("rst_wbusy", mem_wbusy, 0);
      check("rst_waddr", waddr, 0);
      check("rst_wdata", wdata, 0);
      check("rst_wstrb", wstrb, 0);
      check("rst_wen", wen, 0);
      check("rst_raddr", raddr, 0);
      check("rst_ren", ren, 0);
      check("rst_err", err, 0);
      reset_n = 1'b1;

      // Directed cases
      do_write(32'h8000_0004, 32'h0000_00A5, 4'hF, 0, 1'b0);
      do_read(32'h8000_0010, 32'h1234_5678, 3);
      do_read(32'hF123_4568, 32'hCAFE_F00D, int'(TO) - 1);
      check("err_edge_ack", err, 0);

      // Acks while idle are ignored
      @(negedge clk);
      wready = 1'b1; rvalid = 1'b1;
      @(posedge clk); #1;
      wready = 1'b0; rvalid = 1'b0;
      @(negedge clk);
      check("idle_ack_wen", wen, 0);
      check("idle_ack_ren", ren, 0);
      check("idle_ack_rdata", mem_rdata, exp_rdata);

      // Unselected strobes are ignored
      @(negedge clk);
      sel = 1'b0; mem_rstrb = 1'b1; mem_wmask = 4'hF;
      #1;
      check("nosel_rbusy", mem_rbusy, 0);
      check("nosel_wbusy", mem_wbusy, 0);
      @(posedge clk); #1;
      mem_rstrb = 1'b0; mem_wmask = '0;
      @(negedge clk);
      check("nosel_ren", ren, 0);
      check("nosel_wen", wen, 0);

      do_write(32'h0000_0100, 32'h5555_AAAA, 4'h3, 1, 1'b1);
      do_read(32'h1000_0020, 32'h0BAD_0BAD, NEVER);
      do_write(32'h0000_0030, 32'h0000_0001, 4'h1, 2, 1'b0);
      check("err_sticky", err, 1);

      // Randomized transactions
      for (int i = 0; i < 16; i++) begin
         int delay;
         delay = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TO - 2, TO + 3))
                                             : int'($urandom_range(0, 5));
         if ($urandom_range(0, 1) == 1) begin
            do_write($urandom, $urandom, 4'($urandom_range(1, 15)), delay, 1'($urandom));
         end else begin
            do_read($urandom, $urandom, delay);
         end
      end

      // Reset in the middle of a write
      @(negedge clk);
      sel = 1'b1; mem_addr = 32'h0000_0040; mem_wdata = 32'h1111_2222; mem_wmask = 4'hF;
      @(posedge clk); #1;
      sel = 1'b0; mem_wmask = '0;
      @(negedge clk);
      check("pre_rst_wen", wen, 1);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_wen", wen, 0);
      check("async_rst_wbusy", mem_wbusy, 0);
      check("async_rst_err", err, 0);
      check("async_rst_rdata", mem_rdata, 0);
      exp_err = 1'b0;
      exp_rdata = '0;
      @(negedge clk);
      reset_n = 1'b1;
      wready = 1'b1;
      @(posedge clk); #1;
      wready = 1'b0;
      @(negedge clk);
      check("late_ack_wen", wen, 0);
      check("late_ack_wbusy", mem_wbusy, 0);
      check("late_ack_ren", ren, 0);
      check("late_ack_rbusy", mem_rbusy, 0);
      do_read(32'h0000_0044, 32'h7777_8888, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
